spc700_mem_arbiter: RTL and testbench

Parametrised shared-memory block for the SPC700 audio subsystem, the successor to the fixed two-port audio RAM. It holds one single-ported storage array and serves `CLIENTS` requesters through a request/grant handshake with round-robin arbitration. It returns read data with a per-client valid strobe. Typical clients are the APU core, the DSP/BRR fetch path and the host control/loader port.

---
 rtl/spc700_mem_arbiter.sv | 97 +++++++++
 tb/tb_spc700_mem_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spc700_mem_arbiter.sv
// SPC700 shared audio memory: single-port storage, round-robin request/grant.
// Define SPC700_MEM_PRIORITY_EN to give client 0 absolute priority.
module spc700_mem_arbiter #(
  parameter int ADDRESS_BITS = 16,
  parameter int DATA_BITS    = 8,
  parameter int CLIENTS      = 3
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [CLIENTS-1:0]               in_req,
  input  logic [CLIENTS-1:0]               in_we,
  input  logic [CLIENTS*ADDRESS_BITS-1:0]  in_address,
  input  logic [CLIENTS*DATA_BITS-1:0]     in_data,
  output logic [CLIENTS-1:0]               out_grant,
  output logic [CLIENTS-1:0]               out_valid,
  output logic [DATA_BITS-1:0]             out_data
);

  localparam int IDX_W = $clog2(CLIENTS);
  localparam logic [CLIENTS-1:0] ONE = {{(CLIENTS-1){1'b0}}, 1'b1};

  logic [IDX_W-1:0]        last;
  logic [IDX_W-1:0]        win;
  logic [IDX_W-1:0]        cand;
  logic                    any;
  logic [ADDRESS_BITS-1:0] addr;
  logic [DATA_BITS-1:0]    wdata;
  logic                    we;

  logic [DATA_BITS-1:0] mem [0:2**ADDRESS_BITS-1];

  // Search starts just after the previous winner and wraps.
  always_comb begin
    win  = '0;
    cand = '0;
    any  = 1'b0;
    for (int i = 1; i <= CLIENTS; i++) begin
      cand = IDX_W'((int'(last) + i) % CLIENTS);
      if (!any && in_req[cand]) begin
        any = 1'b1;
        win = cand;
      end
    end
`ifdef SPC700_MEM_PRIORITY_EN
    if (in_req[0]) begin
      any = 1'b1;
      win = '0;
    end
`endif
    if (reset) begin
      any = 1'b0;
    end
  end

  assign out_grant = any ? (ONE << win) : '0;

  always_comb begin
    addr  = '0;
    wdata = '0;
    we    = 1'b0;
    for (int k = 0; k < CLIENTS; k++) begin
      if (win == IDX_W'(k)) begin
        addr  = in_address[k*ADDRESS_BITS +: ADDRESS_BITS];
        wdata = in_data[k*DATA_BITS +: DATA_BITS];
        we    = in_we[k];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last      <= IDX_W'(CLIENTS - 1);
      out_valid <= '0;
      out_data  <= '0;
    end else begin
      out_valid <= out_grant;
      if (any) begin
        out_data <= mem[addr];
`ifdef SPC700_MEM_PRIORITY_EN
        if (win != '0) begin
          last <= win;
        end
`else
        last <= win;
`endif
      end
    end
  end

  // Storage is never reset; grant is already masked during reset.
  always_ff @(posedge clock) begin
    if (any && we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: tb/tb_spc700_mem_arbiter.sv
// Self-checking bench for spc700_mem_arbiter.
// Reference model: arbitration rule plus associative-array memory.
module tb_spc700_mem_arbiter;
  localparam int C = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  in_req, in_we, out_grant, out_valid;
  logic [47:0] in_address;
  logic [23:0] in_data;
  logic [7:0]  out_data;

  int checks = 0;
  int errors = 0;
  int last_m;
  logic [7:0] data_m;
  logic [7:0] mem_m [int];

  spc700_mem_arbiter #(.ADDRESS_BITS(16), .DATA_BITS(8), .CLIENTS(C)) dut (
    .clock(clock), .reset(reset), .in_req(in_req), .in_we(in_we),
    .in_address(in_address), .in_data(in_data),
    .out_grant(out_grant), .out_valid(out_valid), .out_data(out_data)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end, got timeout, required finish");
    $fatal(1);
  end

  task apply(input logic [2:0] r, input logic [2:0] w,
             input logic [47:0] a, input logic [23:0] d);
    @(negedge clock);
    in_req = r; in_we = w; in_address = a; in_data = d;
    #1;
  endtask

  task tick;
    @(posedge clock);
    #1;
  endtask

  task model_reset;
    last_m = C - 1;
    data_m = 8'h00;
  endtask

  task do_reset;
    @(negedge clock);
    reset = 1'b1; in_req = '0;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  function automatic int pick(logic [2:0] r);
`ifdef SPC700_MEM_PRIORITY_EN
    if (r[0]) return 0;
`endif
    for (int i = 1; i <= C; i++) begin
      if (r[(last_m + i) % C]) return (last_m + i) % C;
    end
    return -1;
  endfunction

  task commit(input int w, output logic [7:0] prior);
    int a;
    a = int'(in_address[w*16 +: 16]);
    prior = mem_m.exists(a) ? mem_m[a] : 8'hxx;
    if (in_we[w]) mem_m[a] = in_data[w*8 +: 8];
    data_m = prior;
`ifdef SPC700_MEM_PRIORITY_EN
    if (w != 0) last_m = w;
`else
    last_m = w;
`endif
  endtask

  task test_reset;
    logic [7:0] p;
    apply(3'b111, 3'b000, 48'h0, 24'h0);
    reset = 1'b1; #1;
    checks++;
    if (out_grant !== 3'b000) begin
      errors++; $display("FAIL reset_grant: got %b, required 000", out_grant);
    end
    tick();
    checks++;
    if (out_valid !== 3'b000) begin
      errors++; $display("FAIL reset_valid: got %b, required 000", out_valid);
    end
    checks++;
    if (out_data !== 8'h00) begin
      errors++; $display("FAIL reset_data: got %h, required 00", out_data);
    end
    reset = 1'b0;
    model_reset();
    p = 8'h00;
  endtask

  task preload;
    logic [7:0] p;
    int addrs[$];
    logic [7:0] vals[$];
    for (int i = 0; i < 16; i++) begin
      addrs.push_back(i); vals.push_back(8'($urandom));
    end
    addrs.push_back('h10); vals.push_back(8'h61);
    addrs.push_back('h11); vals.push_back(8'h62);
    addrs.push_back('h12); vals.push_back(8'h63);
    addrs.push_back('h00F0); vals.push_back(8'h00);
    addrs.push_back('h1234); vals.push_back(8'h00);
    foreach (addrs[i]) begin
      apply(3'b001, 3'b001, {32'h0, 16'(addrs[i])}, {16'h0, vals[i]});
      tick();
      commit(0, p);
    end
  endtask

  task test_all_read;
    logic [2:0] r;
    logic [7:0] p;
    do_reset();
    r = 3'b111;
    for (int cyc = 0; cyc < 3; cyc++) begin
      apply(r, 3'b000, {16'h0, 16'h12, 16'h11, 16'h10}, 24'h0);
      checks++;
      if (out_grant !== (3'b001 << cyc)) begin
        errors++;
        $display("FAIL all_read_grant c%0d: got %b, required %b",
                 cyc, out_grant, 3'b001 << cyc);
      end
      tick();
      commit(cyc, p);
      checks++;
      if (out_valid !== (3'b001 << cyc) || out_data !== 8'(8'h61 + cyc)) begin
        errors++;
        $display("FAIL all_read_data c%0d: got %b/%h, required %b/%h",
                 cyc, out_valid, out_data, 3'b001 << cyc, 8'(8'h61 + cyc));
      end
      r[cyc] = 1'b0;
    end
  endtask

  task test_write_read;
    logic [7:0] p;
    apply(3'b010, 3'b010, {16'h0, 16'h1234, 16'h0}, {8'h0, 8'hA5, 8'h0});
    checks++;
    if (out_grant !== 3'b010) begin
      errors++; $display("FAIL wr_grant: got %b, required 010", out_grant);
    end
    tick();
    commit(1, p);
    checks++;
    if (out_valid !== 3'b010 || out_data !== 8'h00) begin
      errors++;
      $display("FAIL wr_ack: got %b/%h, required 010/00", out_valid, out_data);
    end
    apply(3'b100, 3'b000, {16'h1234, 16'h0, 16'h0}, 24'h0);
    checks++;
    if (out_grant !== 3'b100) begin
      errors++; $display("FAIL rd_grant: got %b, required 100", out_grant);
    end
    tick();
    commit(2, p);
    checks++;
    if (out_valid !== 3'b100 || out_data !== 8'hA5) begin
      errors++;
      $display("FAIL rd_after_wr: got %b/%h, required 100/a5", out_valid, out_data);
    end
  endtask

  task test_hold;
    logic [7:0] p;
`ifdef SPC700_MEM_PRIORITY_EN
    int exp_w[8] = '{0, 0, 0, 0, 0, 0, 1, 2};
`else
    int exp_w[8] = '{0, 1, 2, 0, 1, 2, 1, 2};
`endif
    do_reset();
    for (int cyc = 0; cyc < 8; cyc++) begin
      apply({2'b11, cyc < 6}, 3'b000, {16'h2, 16'h1, 16'h0}, 24'h0);
      checks++;
      if (out_grant !== (3'b001 << exp_w[cyc])) begin
        errors++;
        $display("FAIL hold_grant c%0d: got %b, required %b",
                 cyc, out_grant, 3'b001 << exp_w[cyc]);
      end
      tick();
      commit(exp_w[cyc], p);
      checks++;
      if (out_valid !== (3'b001 << exp_w[cyc]) || out_data !== data_m) begin
        errors++;
        $display("FAIL hold_data c%0d: got %b/%h, required %b/%h", cyc,
                 out_valid, out_data, 3'b001 << exp_w[cyc], data_m);
      end
    end
  endtask

  task test_reset_mid;
    logic [7:0] p;
    apply(3'b100, 3'b100, {16'h00F0, 32'h0}, {8'h3C, 16'h0});
    reset = 1'b1; #1;
    checks++;
    if (out_grant !== 3'b000) begin
      errors++; $display("FAIL midrst_grant: got %b, required 000", out_grant);
    end
    tick();
    checks++;
    if (out_valid !== 3'b000) begin
      errors++; $display("FAIL midrst_valid: got %b, required 000", out_valid);
    end
    reset = 1'b0;
    model_reset();
    apply(3'b100, 3'b000, {16'h00F0, 32'h0}, 24'h0);
    tick();
    commit(2, p);
    checks++;
    if (out_valid !== 3'b100 || out_data !== 8'h00) begin
      errors++;
      $display("FAIL midrst_read: got %b/%h, required 100/00", out_valid, out_data);
    end
  endtask

  task test_idle;
    logic [7:0] p;
    apply(3'b010, 3'b000, {16'h0, 16'h11, 16'h0}, 24'h0);
    tick();
    commit(1, p);
    for (int cyc = 0; cyc < 4; cyc++) begin
      apply(3'b000, 3'b000, 48'h0, 24'h0);
      checks++;
      if (out_grant !== 3'b000) begin
        errors++; $display("FAIL idle_grant c%0d: got %b, required 000", cyc, out_grant);
      end
      tick();
      checks++;
      if (out_valid !== 3'b000 || out_data !== 8'h62) begin
        errors++;
        $display("FAIL idle_hold c%0d: got %b/%h, required 000/62",
                 cyc, out_valid, out_data);
      end
    end
  endtask

  task test_random;
    logic [2:0]  r, w;
    logic [47:0] a;
    logic [23:0] d;
    logic [2:0]  exp_g;
    logic [7:0]  p;
    int waits[C];
    int win;
    r = '0; w = '0; a = '0; d = '0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      for (int k = 0; k < C; k++) begin
        if (!r[k] && $urandom_range(0, 1) == 1) begin
          r[k] = 1'b1;
          w[k] = 1'($urandom_range(0, 1));
          a[k*16 +: 16] = 16'($urandom_range(0, 15));
          d[k*8 +: 8] = 8'($urandom);
          waits[k] = 0;
        end
      end
      apply(r, w, a, d);
      win = pick(r);
      exp_g = (win < 0) ? 3'b000 : (3'b001 << win);
      checks++;
      if (out_grant !== exp_g) begin
        errors++;
        $display("FAIL rand_grant c%0d: got %b, required %b", cyc, out_grant, exp_g);
      end
`ifndef SPC700_MEM_PRIORITY_EN
      for (int k = 0; k < C; k++) begin
        if (r[k] && k != win) begin
          waits[k]++;
          checks++;
          if (waits[k] >= C) begin
            errors++;
            $display("FAIL rand_starve c%0d k%0d: got wait %0d, required < %0d",
                     cyc, k, waits[k], C);
          end
        end
      end
`endif
      tick();
      if (win >= 0) begin
        commit(win, p);
        r[win] = 1'b0;
      end
      checks++;
      if (out_valid !== exp_g || out_data !== data_m) begin
        errors++;
        $display("FAIL rand_resp c%0d: got %b/%h, required %b/%h",
                 cyc, out_valid, out_data, exp_g, data_m);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    in_req = '0; in_we = '0; in_address = '0; in_data = '0;
    model_reset();
    repeat (2) @(negedge clock);
    test_reset();
    preload();
    test_all_read();
    test_write_read();
    test_hold();
    test_reset_mid();
    test_idle();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
